// File: rtl/iq_player_8k_32b.sv
// TX IQ playout buffer: host I/Q words packed into 32b pairs, 8K-deep BRAM FIFO,
// popped one pair per play strobe behind a prime/run FSM. Optional: IQ_PLAYER_UNDERRUN_CNT_EN.
module iq_player_8k_32b #(
    parameter int A_MSB     = 12,
    parameter int PRIME_LVL = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_i,
    input  logic              wr_q,
    input  logic [15:0]       wr_data,
    input  logic              flush,
    input  logic              enable,
    input  logic              play,
    output logic [15:0]       play_i,
    output logic [15:0]       play_q,
    output logic              play_valid,
    output logic              running,
    output logic [A_MSB+1:0]  fill,
    output logic              overflow,
    output logic [15:0]       underruns
);
    localparam int DEPTH = 1 << (A_MSB + 1);
    localparam logic [A_MSB+1:0] DEPTH_C = DEPTH[A_MSB+1:0];
    localparam logic [A_MSB+1:0] PRIME_C = PRIME_LVL[A_MSB+1:0];
    localparam logic [A_MSB+1:0] CNT_ONE = 1;
    localparam logic [A_MSB:0]   ADR_ONE = 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t            state_q, state_d;
    logic [A_MSB+1:0]  count_q, count_d;
    logic [A_MSB:0]    wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [15:0]       i_hold_q, i_hold_d;
    logic              overflow_q, overflow_d;
    logic [2:1]        vld_pipe_q, vld_pipe_d;
    logic              zero_q, zero_d;
    logic [15:0]       play_i_q, play_i_d, play_q_q, play_q_d;
    logic [31:0]       rd_data_q;
    logic [31:0]       mem [DEPTH];
    logic              emit, pop, push, full;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        i_hold_d   = i_hold_q;
        overflow_d = overflow_q;
        full       = (count_q == DEPTH_C);
        emit       = play && (state_q != IDLE) && !flush;
        pop        = play && (state_q == RUN) && (count_q != '0) && !flush;
        push       = wr_q && !full && !flush;
        zero_d     = !pop;
        vld_pipe_d = {vld_pipe_q[1], emit};
        play_i_d   = play_i_q;
        play_q_d   = play_q_q;

        if (wr_i) i_hold_d = wr_data;
        if (push) wr_addr_d = wr_addr_q + ADR_ONE;
        if (pop)  rd_addr_d = rd_addr_q + ADR_ONE;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
        if (wr_q && full && !flush) overflow_d = 1'b1;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = PRIME;
                PRIME:   if (count_q >= PRIME_C) state_d = RUN;
                RUN:     if (play && (count_q == '0)) state_d = PRIME;
                default: state_d = IDLE;
            endcase
        end

        if (flush) begin
            count_d    = '0;
            wr_addr_d  = '0;
            rd_addr_d  = '0;
            i_hold_d   = '0;
            overflow_d = 1'b0;
            state_d    = enable ? PRIME : IDLE;
        end

        // Stage 2: PRIME and underrun strobes still yield a (zero) sample.
        if (vld_pipe_q[1]) begin
            play_i_d = zero_q ? 16'h0 : rd_data_q[31:16];
            play_q_d = zero_q ? 16'h0 : rd_data_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_addr_q] <= {i_hold_q, wr_data};
        if (pop)  rd_data_q <= mem[rd_addr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            i_hold_q   <= '0;
            overflow_q <= 1'b0;
            vld_pipe_q <= '0;
            zero_q     <= 1'b1;
            play_i_q   <= '0;
            play_q_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            i_hold_q   <= i_hold_d;
            overflow_q <= overflow_d;
            vld_pipe_q <= vld_pipe_d;
            zero_q     <= zero_d;
            play_i_q   <= play_i_d;
            play_q_q   <= play_q_d;
        end
    end

`ifdef IQ_PLAYER_UNDERRUN_CNT_EN
    logic [15:0] unr_q, unr_d;
    logic        underrun;

    always_comb begin
        underrun = play && (state_q == RUN) && (count_q == '0) && !flush;
        unr_d    = unr_q;
        if (flush) unr_d = '0;
        else if (underrun && (unr_q != 16'hFFFF)) unr_d = unr_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) unr_q <= '0;
        else        unr_q <= unr_d;
    end

    assign underruns = unr_q;
`else
    assign underruns = '0;
`endif

    assign play_i     = play_i_q;
    assign play_q     = play_q_q;
    assign play_valid = vld_pipe_q[2];
    assign running    = (state_q == RUN);
    assign fill       = count_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_iq_player_8k_32b.sv
// Directed bench for iq_player_8k_32b: a queue-based FIFO model supplies expected
// pairs, pushed to a scoreboard at each play strobe and popped at play_valid.
module tb_iq_player_8k_32b;
    logic        clk = 1'b0;
    logic        rst_n, wr_i, wr_q, flush, enable, play;
    logic [15:0] wr_data, play_i, play_q, underruns;
    logic        play_valid, running, overflow;
    logic [13:0] fill;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mf[$];
    logic [31:0] sb[$];
    logic [15:0] m_hold;
    logic        m_ovf;
    int          m_unr;

`ifdef IQ_PLAYER_UNDERRUN_CNT_EN
    localparam int UNR_EN = 1;
`else
    localparam int UNR_EN = 0;
`endif

    iq_player_8k_32b dut (
        .clk(clk), .rst_n(rst_n), .wr_i(wr_i), .wr_q(wr_q), .wr_data(wr_data),
        .flush(flush), .enable(enable), .play(play), .play_i(play_i), .play_q(play_q),
        .play_valid(play_valid), .running(running), .fill(fill), .overflow(overflow),
        .underruns(underruns)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_pair(input logic [15:0] i, input logic [15:0] q);
        wr_i = 1'b1; wr_data = i;
        tick();
        wr_i = 1'b0; m_hold = i;
        wr_q = 1'b1; wr_data = q;
        tick();
        wr_q = 1'b0;
        if (mf.size() < 8192) mf.push_back({m_hold, q});
        else m_ovf = 1'b1;
    endtask

    // One play strobe; optionally a same-cycle wr_q of {hold, q}.
    task automatic do_play(input bit run, input bit with_wr, input logic [15:0] q);
        logic [31:0] e;
        e = 32'h0;
        if (run && mf.size() != 0) e = mf.pop_front();
        else if (run) m_unr++;
        sb.push_back(e);
        if (with_wr) mf.push_back({m_hold, q});
        play = 1'b1; wr_q = with_wr; wr_data = q;
        tick();
        play = 1'b0; wr_q = 1'b0;
        chk("valid_n1", {31'h0, play_valid}, 32'h0);
        tick();
        chk("valid_n2", {31'h0, play_valid}, 32'h1);
        if (sb.size() != 0) chk("iq_data", {play_i, play_q}, sb.pop_front());
    endtask

    initial begin
        rst_n = 1'b0; wr_i = 1'b0; wr_q = 1'b0; wr_data = '0;
        flush = 1'b0; enable = 1'b0; play = 1'b0;
        m_hold = '0; m_ovf = 1'b0; m_unr = 0;
        tick(); tick();
        chk("rst_play_i", {16'h0, play_i}, 32'h0);
        chk("rst_play_q", {16'h0, play_q}, 32'h0);
        chk("rst_valid", {31'h0, play_valid}, 32'h0);
        chk("rst_running", {31'h0, running}, 32'h0);
        chk("rst_fill", {18'h0, fill}, 32'h0);
        chk("rst_overflow", {31'h0, overflow}, 32'h0);
        chk("rst_underruns", {16'h0, underruns}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Prime with 2048 pairs, then play a few.
        enable = 1'b1;
        for (int k = 0; k < 2048; k++) begin
            wr_pair(16'(k), ~16'(k));
            if (k == 2046) chk("prime_not_run", {31'h0, running}, 32'h0);
        end
        chk("prime_fill", {18'h0, fill}, 32'd2048);
        chk("prime_run_lag", {31'h0, running}, 32'h0);
        tick();
        chk("prime_running", {31'h0, running}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            do_play(1'b1, 1'b0, 16'h0);
            chk("run_fill_dec", {18'h0, fill}, mf.size());
        end

        // flush in RUN with a same-cycle write.
        flush = 1'b1; wr_q = 1'b1; wr_data = 16'hBEEF;
        tick();
        flush = 1'b0; wr_q = 1'b0;
        mf.delete(); m_hold = '0; m_ovf = 1'b0; m_unr = 0;
        chk("flush_fill", {18'h0, fill}, 32'h0);
        chk("flush_ovf", {31'h0, overflow}, 32'h0);
        chk("flush_unr", {16'h0, underruns}, 32'h0);
        chk("flush_running", {31'h0, running}, 32'h0);
        do_play(1'b0, 1'b0, 16'h0);

        // Overflow: 8193 pairs while disabled.
        enable = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 8193; k++) wr_pair(16'(k), ~16'(k));
        chk("ovf_fill", {18'h0, fill}, 32'd8192);
        chk("ovf_flag", {31'h0, overflow}, {31'h0, m_ovf});
        chk("idle_running", {31'h0, running}, 32'h0);
        enable = 1'b1;
        tick(); tick();
        chk("ovf_running", {31'h0, running}, 32'h1);
        for (int k = 0; k < 8192; k++) do_play(1'b1, 1'b0, 16'h0);
        chk("drain_fill", {18'h0, fill}, 32'h0);
        do_play(1'b1, 1'b0, 16'h0);
        chk("unr_count", {16'h0, underruns}, UNR_EN * m_unr);
        chk("unr_running", {31'h0, running}, 32'h0);

        // Refill across pointer wrap, then push+pop at fill=100.
        for (int k = 0; k < 2048; k++) begin
            wr_pair(16'(k + 16'h4000), 16'(k + 16'h9000));
            if (k == 2046) chk("refill_not_run", {31'h0, running}, 32'h0);
        end
        tick();
        chk("refill_running", {31'h0, running}, 32'h1);
        for (int k = 0; k < 1948; k++) do_play(1'b1, 1'b0, 16'h0);
        chk("fill_100", {18'h0, fill}, 32'd100);
        wr_i = 1'b1; wr_data = 16'hAAAA;
        tick();
        wr_i = 1'b0; m_hold = 16'hAAAA;
        do_play(1'b1, 1'b1, 16'h5555);
        chk("pushpop_fill", {18'h0, fill}, 32'd100);
        for (int k = 0; k < 3; k++) do_play(1'b1, 1'b0, 16'h0);
        chk("unr_hold", {16'h0, underruns}, UNR_EN * m_unr);

        // Reset between a strobe and its play_valid.
        play = 1'b1;
        tick();
        play = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, play_valid}, 32'h0);
        chk("mid_rst_iq", {play_i, play_q}, 32'h0);
        chk("mid_rst_fill", {18'h0, fill}, 32'h0);
        chk("mid_rst_running", {31'h0, running}, 32'h0);
        tick();
        chk("mid_rst_valid2", {31'h0, play_valid}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", {31'h0, play_valid}, 32'h0);
        chk("post_rst_ovf", {31'h0, overflow}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
